// File: rtl/cp0_reg.sv
// CP0 register file and exception commit unit at the write-back end of the pipeline.
// Commits mtc0/eret, takes exceptions and interrupts, runs Count/Compare and serves mfc0.
module cp0_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [31:0] i_pc,
   input  logic        i_mtc0_we,
   input  logic [4:0]  i_c0_addr,
   input  logic [31:0] i_c0_wdata,
   input  logic [6:0]  i_except,
   input  logic        i_bd,
   input  logic        i_eret,
   input  logic [31:0] i_bad_vaddr,
   input  logic [5:0]  i_int,
   input  logic [4:0]  i_raddr,
   output logic [31:0] o_rdata,
   output logic        o_flush,
   output logic [31:0] o_new_pc,
   output logic [31:0] o_status,
   output logic [31:0] o_cause,
   output logic [31:0] o_epc,
   output logic        o_timer_int
);
   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;

   typedef enum logic [1:0] {BV_NONE, BV_PC, BV_VADDR} badv_sel_e;

   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] epc_q, epc_d;
   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic        ti_q, ti_d;
   logic        tick_q, tick_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [1:0]  ip_sw_q, ip_sw_d;

   logic        live_valid;
   logic [7:0]  ip;
   logic [31:0] status_val, cause_val;
   logic        int_pending, exc_taken, eret_commit, wr_en;
   logic [4:0]  exc_code;
   badv_sel_e   badv_sel;
   logic [31:0] wr_masked;
   logic        wr_addr_ok;

   // While reset is held the outputs must look like the reset state, so inputs are masked off.
   assign live_valid = i_valid & ~reset;
   assign ip         = reset ? 8'h00 : {i_int[5] | ti_q, i_int[4:0], ip_sw_q};
   assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_val  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

   assign int_pending = live_valid & ie_q & ~exl_q & (|(ip & im_q));
   assign exc_taken   = int_pending | (live_valid & (|i_except));
   assign eret_commit = live_valid & i_eret & ~exc_taken;
   assign wr_en       = live_valid & i_mtc0_we & ~exc_taken;

   always_comb begin
      exc_code = 5'd0;
      badv_sel = BV_NONE;
      if (int_pending)      exc_code = 5'd0;
      else if (i_except[0]) begin exc_code = 5'd4;  badv_sel = BV_PC;    end
      else if (i_except[1]) exc_code = 5'd10;
      else if (i_except[2]) exc_code = 5'd12;
      else if (i_except[3]) exc_code = 5'd8;
      else if (i_except[4]) exc_code = 5'd9;
      else if (i_except[5]) begin exc_code = 5'd4;  badv_sel = BV_VADDR; end
      else if (i_except[6]) begin exc_code = 5'd5;  badv_sel = BV_VADDR; end
   end

   assign o_flush  = exc_taken | eret_commit;
   assign o_new_pc = exc_taken ? EXC_VECTOR : (eret_commit ? epc_q : 32'h0);

   // Value an mtc0 would leave in the destination; BadVAddr and unlisted numbers take no write.
   always_comb begin
      wr_masked  = 32'h0;
      wr_addr_ok = 1'b1;
      case (i_c0_addr)
         A_COUNT, A_COMPARE, A_EPC: wr_masked = i_c0_wdata;
         A_STATUS: wr_masked = (i_c0_wdata & STATUS_WMASK) | STATUS_BEV;
         A_CAUSE:  wr_masked = i_c0_wdata & CAUSE_WMASK;
         default:  wr_addr_ok = 1'b0;
      endcase
   end

   always_comb begin
      o_rdata = 32'h0;
      if (live_valid && i_mtc0_we && wr_addr_ok && (i_c0_addr == i_raddr)) begin
         o_rdata = wr_masked;
      end else begin
         case (i_raddr)
            A_BADVADDR: o_rdata = badvaddr_q;
            A_COUNT:    o_rdata = count_q;
            A_COMPARE:  o_rdata = compare_q;
            A_STATUS:   o_rdata = status_val;
            A_CAUSE:    o_rdata = cause_val;
            A_EPC:      o_rdata = epc_q;
            default:    o_rdata = 32'h0;
         endcase
      end
   end

   always_comb begin
      tick_d     = ~tick_q;
      count_d    = count_q + {31'b0, tick_q};
      compare_d  = compare_q;
      ti_d       = ti_q;
      badvaddr_d = badvaddr_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exccode_d  = exccode_q;
      ip_sw_d    = ip_sw_q;

      if (count_q == compare_q) ti_d = 1'b1;

      if (wr_en) begin
         case (i_c0_addr)
            A_COUNT:   count_d = i_c0_wdata;
            A_COMPARE: begin compare_d = i_c0_wdata; ti_d = 1'b0; end
            A_STATUS:  begin
               im_d  = i_c0_wdata[15:8];
               exl_d = i_c0_wdata[1];
               ie_d  = i_c0_wdata[0];
            end
            A_CAUSE:   ip_sw_d = i_c0_wdata[9:8];
            A_EPC:     epc_d = i_c0_wdata;
            default:   ;
         endcase
      end

      if (eret_commit) exl_d = 1'b0;

      if (exc_taken) begin
         exl_d     = 1'b1;
         exccode_d = exc_code;
         // A nested exception keeps the original return point.
         if (!exl_q) begin
            epc_d = i_bd ? (i_pc - 32'd4) : i_pc;
            bd_d  = i_bd;
         end
         if (badv_sel == BV_PC)    badvaddr_d = i_pc;
         if (badv_sel == BV_VADDR) badvaddr_d = i_bad_vaddr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         badvaddr_q <= 32'h0;
         count_q    <= 32'h0;
         compare_q  <= 32'h0;
         epc_q      <= 32'h0;
         im_q       <= 8'h0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         tick_q     <= 1'b0;
         exccode_q  <= 5'h0;
         ip_sw_q    <= 2'h0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         tick_q     <= tick_d;
         exccode_q  <= exccode_d;
         ip_sw_q    <= ip_sw_d;
      end
   end

   assign o_status    = status_val;
   assign o_cause     = cause_val;
   assign o_epc       = epc_q;
   assign o_timer_int = ti_q;
endmodule

// File: tb/tb_cp0_reg.sv
// Randomized and directed bench for cp0_reg, checked every cycle against a behavioural CP0 model.
module tb_cp0_reg;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0;
   logic [31:0] i_pc = 32'h0;
   logic        i_mtc0_we = 1'b0;
   logic [4:0]  i_c0_addr = 5'd0;
   logic [31:0] i_c0_wdata = 32'h0;
   logic [6:0]  i_except = 7'h0;
   logic        i_bd = 1'b0;
   logic        i_eret = 1'b0;
   logic [31:0] i_bad_vaddr = 32'h0;
   logic [5:0]  i_int = 6'h0;
   logic [4:0]  i_raddr = 5'd0;
   logic [31:0] o_rdata, o_new_pc, o_status, o_cause, o_epc;
   logic        o_flush, o_timer_int;

   int n_cmp = 0;
   int n_err = 0;
   bit run = 1'b0;

   cp0_reg dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_pc(i_pc),
      .i_mtc0_we(i_mtc0_we), .i_c0_addr(i_c0_addr), .i_c0_wdata(i_c0_wdata),
      .i_except(i_except), .i_bd(i_bd), .i_eret(i_eret), .i_bad_vaddr(i_bad_vaddr),
      .i_int(i_int), .i_raddr(i_raddr), .o_rdata(o_rdata), .o_flush(o_flush),
      .o_new_pc(o_new_pc), .o_status(o_status), .o_cause(o_cause), .o_epc(o_epc),
      .o_timer_int(o_timer_int)
   );

   always #5 clk = ~clk;

   // Architectural CP0 state as seen by software.
   bit [31:0] m_badv, m_count, m_compare, m_epc;
   bit [7:0]  m_im;
   bit        m_exl, m_ie, m_bd, m_ti, m_tick;
   bit [4:0]  m_code;
   bit [1:0]  m_ipsw;
   int        codes [8] = '{4, 10, 12, 8, 9, 4, 5, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [7:0] m_ip();
      if (reset) return 8'h00;
      return {i_int[5] | m_ti, i_int[4:0], m_ipsw};
   endfunction

   function automatic bit [31:0] m_status();
      return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
   endfunction

   function automatic bit [31:0] m_cause();
      return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
   endfunction

   function automatic bit [31:0] m_read(input bit [4:0] a);
      case (a)
         5'd8:  return m_badv;
         5'd9:  return m_count;
         5'd11: return m_compare;
         5'd12: return m_status();
         5'd13: return m_cause();
         5'd14: return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0; m_im = 0;
      m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_tick = 0; m_code = 0; m_ipsw = 0;
   endtask

   // Compare process: check outputs mid-cycle, then advance the model to the post-edge state.
   always @(negedge clk) begin
      if (run) begin
         bit v, intp, exc, wr, er, bypass, old_exl;
         int win;
         bit [31:0] exp_rd, old_count, old_cmp;
         if (reset) model_reset();
         v = i_valid && !reset;
         intp = v && m_ie && !m_exl && ((m_ip() & m_im) != 0);
         win = -1;
         if (intp) win = 7;
         else if (v) begin
            for (int i = 0; i < 7; i++) if (win < 0 && i_except[i]) win = i;
         end
         exc = (win >= 0);
         wr = v && i_mtc0_we && !exc;
         er = v && i_eret && !exc;
         bypass = v && i_mtc0_we && (i_c0_addr == i_raddr) &&
                  (i_c0_addr inside {5'd9, 5'd11, 5'd12, 5'd13, 5'd14});
         if (!bypass) exp_rd = m_read(i_raddr);
         else if (i_c0_addr == 5'd12) exp_rd = (i_c0_wdata & 32'h0000_FF03) | 32'h0040_0000;
         else if (i_c0_addr == 5'd13) exp_rd = i_c0_wdata & 32'h0000_0300;
         else exp_rd = i_c0_wdata;

         chk("flush", {31'b0, o_flush}, {31'b0, exc || er});
         if (exc || er) chk("new_pc", o_new_pc, exc ? 32'hBFC0_0380 : m_epc);
         chk("rdata", o_rdata, exp_rd);
         chk("status", o_status, m_status());
         chk("cause", o_cause, m_cause());
         chk("epc", o_epc, m_epc);
         chk("timer_int", {31'b0, o_timer_int}, {31'b0, m_ti});

         if (!reset) begin
            old_count = m_count; old_cmp = m_compare; old_exl = m_exl;
            if (wr && i_c0_addr == 5'd9) m_count = i_c0_wdata;
            else m_count = m_count + 32'(m_tick);
            m_tick = !m_tick;
            if (wr && i_c0_addr == 5'd11) m_ti = 0;
            else if (old_count == old_cmp) m_ti = 1;
            if (wr) begin
               if (i_c0_addr == 5'd11) m_compare = i_c0_wdata;
               if (i_c0_addr == 5'd12) begin
                  m_im = i_c0_wdata[15:8]; m_exl = i_c0_wdata[1]; m_ie = i_c0_wdata[0];
               end
               if (i_c0_addr == 5'd13) m_ipsw = i_c0_wdata[9:8];
               if (i_c0_addr == 5'd14) m_epc = i_c0_wdata;
            end
            if (er) m_exl = 0;
            if (exc) begin
               if (!old_exl) begin
                  m_epc = i_bd ? i_pc - 32'd4 : i_pc;
                  m_bd = i_bd;
               end
               m_exl = 1;
               m_code = 5'(codes[win]);
               if (win == 0) m_badv = i_pc;
               if (win == 5 || win == 6) m_badv = i_bad_vaddr;
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_valid = 0; i_mtc0_we = 0; i_except = 0; i_eret = 0; i_bd = 0;
   endtask

   task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
      idle(); i_valid = 1; i_mtc0_we = 1; i_c0_addr = a; i_c0_wdata = d;
      $display("txn mtc0 r%0d <= %h", a, d);
      cycle();
      idle();
   endtask

   initial begin
      bit seen;
      run = 1;
      cycle(); cycle();
      reset = 0;
      i_raddr = 5'd9;
      for (int i = 0; i < 10; i++) cycle();
      $display("txn free-run 10 cycles count=%0d", o_rdata);
      chk("lit_count5", o_rdata, 32'd5);
      chk("lit_model_count5", m_count, 32'd5);
      chk("lit_status_reset", o_status, 32'h0040_0000);

      mtc0(5'd11, 32'd20);
      mtc0(5'd12, 32'h0000_8001);
      seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         if (o_timer_int) seen = 1; else cycle();
      end
      chk("lit_ti_seen", {31'b0, o_timer_int}, 32'd1);
      chk("lit_ti_count", o_rdata, 32'd20);

      idle(); i_valid = 1; i_pc = 32'h8000_0040; #1;
      $display("txn timer interrupt slot pc=%h flush=%b", i_pc, o_flush);
      chk("lit_int_flush", {31'b0, o_flush}, 32'd1);
      chk("lit_int_newpc", o_new_pc, 32'hBFC0_0380);
      cycle(); idle();
      chk("lit_int_code", {27'b0, o_cause[6:2]}, 32'd0);
      chk("lit_int_exl", {31'b0, o_status[1]}, 32'd1);
      chk("lit_int_epc", o_epc, 32'h8000_0040);

      mtc0(5'd11, 32'h0000_1000);
      mtc0(5'd14, 32'h8000_0300);
      i_valid = 1; i_eret = 1; #1;
      $display("txn eret flush=%b new_pc=%h", o_flush, o_new_pc);
      chk("lit_eret_flush", {31'b0, o_flush}, 32'd1);
      chk("lit_eret_newpc", o_new_pc, 32'h8000_0300);
      cycle(); idle();
      chk("lit_eret_exl", {31'b0, o_status[1]}, 32'd0);

      i_valid = 1; i_except = 7'b000_0110; i_bd = 1; i_pc = 32'h8000_0104;
      $display("txn RI+Ov in delay slot pc=%h", i_pc);
      cycle(); idle();
      chk("lit_ri_code", {27'b0, o_cause[6:2]}, 32'd10);
      chk("lit_ri_epc", o_epc, 32'h8000_0100);
      chk("lit_ri_bd", {31'b0, o_cause[31]}, 32'd1);

      i_valid = 1; i_except = 7'b100_0000; i_pc = 32'h8000_0200; i_bad_vaddr = 32'h3;
      i_mtc0_we = 1; i_c0_addr = 5'd14; i_c0_wdata = 32'hDEAD_BEEF;
      $display("txn nested AdES with suppressed mtc0");
      cycle(); idle();
      i_raddr = 5'd8; #1;
      chk("lit_ades_badv", o_rdata, 32'h3);
      chk("lit_ades_code", {27'b0, o_cause[6:2]}, 32'd5);
      chk("lit_ades_epc", o_epc, 32'h8000_0100);

      i_valid = 1; i_eret = 1; i_except = 7'b000_1000; #1;
      $display("txn eret + syscall same slot");
      chk("lit_exc_eret_pc", o_new_pc, 32'hBFC0_0380);
      cycle(); idle();
      chk("lit_exc_eret_exl", {31'b0, o_status[1]}, 32'd1);

      i_raddr = 5'd9; i_valid = 1; i_mtc0_we = 1; i_c0_addr = 5'd9; i_c0_wdata = 32'hFFFF_FFFF; #1;
      $display("txn mtc0 Count=ffffffff with bypass read");
      chk("lit_bypass", o_rdata, 32'hFFFF_FFFF);
      cycle(); idle(); cycle(); cycle();
      chk("lit_count_wrap", o_rdata, 32'h0);

      reset = 1; cycle(); reset = 0;
      for (int t = 0; t < 1500; t++) begin
         int r;
         idle();
         reset = ($urandom_range(0, 149) == 0);
         i_valid = ($urandom_range(0, 3) != 0);
         i_pc = $urandom & 32'hFFFF_FFFC;
         i_bd = $urandom_range(0, 1);
         i_mtc0_we = ($urandom_range(0, 9) < 3);
         r = $urandom_range(0, 6);
         i_c0_addr = (r == 6) ? 5'($urandom) : 5'(r == 0 ? 8 : r == 1 ? 9 : r == 2 ? 11 :
                                                 r == 3 ? 12 : r == 4 ? 13 : 14);
         i_c0_wdata = (i_c0_addr == 5'd11) ? m_count + $urandom_range(0, 6) : $urandom;
         i_except = ($urandom_range(0, 9) < 2) ? 7'($urandom) : 7'h0;
         i_eret = ($urandom_range(0, 9) == 0);
         i_bad_vaddr = $urandom;
         i_int = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
         i_raddr = ($urandom_range(0, 3) == 0) ? i_c0_addr : 5'($urandom_range(8, 15));
         #1;
         $display("txn %0d rst=%b v=%b we=%b a=%0d exc=%b eret=%b flush=%b",
                  t, reset, i_valid, i_mtc0_we, i_c0_addr, i_except, i_eret, o_flush);
         cycle();
      end
      reset = 0; idle(); cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file and exception commit unit for the MIPS pipeline. It sits at the write-back end of the mem/wb pipeline register and consumes that register's CP0 and exception fields: mtc0 write, exception vector, branch-delay flag and eret. It commits CP0 writes, takes exceptions and interrupts, and drives the pipeline flush and redirect PC. It also runs the Count/Compare timer and serves mfc0 reads.

## Interface
- EXC_VECTOR, 32'hBFC0_0380: redirect PC for every exception and interrupt.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- i_valid  in  1  write-back slot holds a real instruction; 0 for a bubble or flushed slot.
- i_pc  in  32  PC of the write-back instruction.
- i_mtc0_we  in  1  mtc0 commit.
- i_c0_addr  in  5  mtc0 destination register number.
- i_c0_wdata  in  32  mtc0 data.
- i_except  in  7  exception flags:
  - [0] fetch AdEL
  - [1] RI
  - [2] Ov
  - [3] Syscall
  - [4] Break
  - [5] load AdEL
  - [6] store AdES
- i_bd  in  1  the instruction is in a branch-delay slot.
- i_eret  in  1  eret commit.
- i_bad_vaddr  in  32  data address for flags [5] and [6].
- i_int  in  6  external hardware interrupts, level-sensitive, feed Cause.IP[7:2].
- i_raddr  in  5  mfc0 read register number.
- o_rdata  out  32  mfc0 read data.
- o_flush  out  1  flush every pipeline stage.
- o_new_pc  out  32  redirect target; valid while o_flush=1.
- o_status, o_cause, o_epc  out  32 each  current register values.
- o_timer_int  out  1  Cause.TI.

## Operation
- Registers and reset values:
  - BadVAddr (8): 0.
  - Count (9): 0.
  - Compare (11): 0.
  - Status (12): 32'h0040_0000.
  - Cause (13): 0.
  - EPC (14): 0.
- Status: BEV bit 22 is read-only 1. Writable bits are IM[15:8], EXL[1] and IE[0]. All other bits read 0.
- Cause:
  - BD[31] and ExcCode[6:2] are hardware-only.
  - TI[30] is hardware-only.
  - IP[7:2] (bits 15:10) = {i_int[5] | TI, i_int[4:0]}, sampled every cycle.
  - IP[1:0] (bits 9:8) are software-writable.
  - All other bits read 0.
- BadVAddr is read-only to mtc0. A write to any unlisted register number is ignored.
- Interrupt pending = i_valid & Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Exception taken = interrupt pending | (i_valid & |i_except).
- Priority and ExcCode, first match wins:
  - interrupt: 0
  - [0]: 4
  - [1]: 10
  - [2]: 12
  - [3]: 8
  - [4]: 9
  - [5]: 4
  - [6]: 5
- On an exception, at the clock edge:
  - Status.EXL <= 1.
  - Cause.ExcCode <= code.
  - If EXL was 0: EPC <= i_bd ? i_pc-4 : i_pc, and Cause.BD <= i_bd. If EXL was already 1, EPC and BD are unchanged.
  - BadVAddr <= i_pc for [0]; BadVAddr <= i_bad_vaddr for [5] or [6].
  - The mtc0 of the same slot is suppressed.
- eret (i_valid & i_eret & no exception): Status.EXL <= 0; o_flush=1; o_new_pc=EPC.
- mtc0 (i_valid & i_mtc0_we & no exception) writes the masked bits.
- Compare write clears TI.
- Count:
  - A 1-bit tick toggles every cycle; Count increments when tick=1, i.e. every second cycle, wrapping at 2^32.
  - An mtc0 write to Count wins over the increment.
- TI is set in any cycle where Count==Compare and Compare is not being written. It stays set until a Compare write.
- o_rdata is combinational from i_raddr. If i_mtc0_we & i_valid & i_c0_addr==i_raddr, it returns the masked i_c0_wdata (bypass). Unlisted addresses read 0.

## Timing
- o_flush and o_new_pc are combinational in the same cycle as the committing instruction.
- Register updates are visible from the next cycle.
- Reset asserted: o_flush=0, o_rdata reflects the reset values, and the tick clears.
- Reset asserted mid-exception: no state update completes.
- Exception and eret in the same slot: the exception wins and EXL stays 1.
- A slot with i_valid=0 never flushes, writes or traps. Interrupts wait for the next valid slot.

## Test plan
- Reset, then free-run 10 cycles -> Count=5, Status=32'h0040_0000, o_flush=0 throughout.
- mtc0 Compare=20, Status=32'h0000_8001 (IM7, IE), then run -> TI=1 when Count=20. On the next valid slot: o_flush=1, o_new_pc=32'hBFC0_0380, ExcCode=0, EXL=1, EPC=that PC.
- i_except=7'b000_0010 with i_except[2] also set, i_bd=1, i_pc=32'h8000_0104 -> ExcCode=10, EPC=32'h8000_0100, Cause.BD=1.
- With EXL=1, store AdES at i_pc=32'h8000_0200, i_bad_vaddr=32'h0000_0003 -> BadVAddr=3, ExcCode=5, EPC unchanged.
- eret with EPC=32'h8000_0300 -> o_flush=1, o_new_pc=32'h8000_0300, EXL=0 next cycle.
- mtc0 Count=32'hFFFF_FFFF with a same-cycle mfc0 of register 9 -> o_rdata=32'hFFFF_FFFF, and Count wraps to 0 within two cycles. mtc0 accompanied by an exception -> write suppressed.
